// File: rtl/sram_arbiter_if.sv
// Bus between two requesters, the SRAM arbiter and the SRAM array port.
// slave: arbiter side; master: requesters plus array model.
interface sram_arbiter_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned AW     = 5
);
   logic [1:0]          req;
   logic [1:0]          we;
   logic [2*AW-1:0]     addr;
   logic [2*DATA_W-1:0] wdata;
   logic [1:0]          gnt;
   logic [1:0]          done;
   logic [DATA_W-1:0]   rdata;
   logic [AW-1:0]       sram_sel;
   logic                sram_en;
   logic                sram_we;
   logic [DATA_W-1:0]   sram_wdata;
   logic [DATA_W-1:0]   sram_rdata;

   modport slave (
      input  req, we, addr, wdata, sram_rdata,
      output gnt, done, rdata, sram_sel, sram_en, sram_we, sram_wdata
   );

   modport master (
      output req, we, addr, wdata, sram_rdata,
      input  gnt, done, rdata, sram_sel, sram_en, sram_we, sram_wdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for a 32-word SRAM; 4-cycle access (IDLE/SETUP/STROBE/DONE).
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin; default build is fixed priority (req 0 wins).
module sram_arbiter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NWORDS = 32
) (
   input logic            clk,
   input logic            rst_n,
   sram_arbiter_if.slave  bus
);
   localparam int unsigned AW = $clog2(NWORDS);

   typedef enum logic [1:0] {StIdle, StSetup, StStrobe, StDone} state_e;

   state_e            state_q, state_d;
   logic              win_q, win_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [1:0]        done_q, done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [AW-1:0]     sel_q, sel_d;
   logic              en_q, en_d;
   logic              swe_q, swe_d;
   logic [DATA_W-1:0] swdata_q, swdata_d;
   logic              win_c;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
   logic last_q, last_d;

   // On a tie the requester not granted last wins.
   always_comb begin
      if (bus.req == 2'b11) win_c = ~last_q;
      else                  win_c = bus.req[1];
   end
`else
   always_comb win_c = ~bus.req[0];
`endif

   always_comb begin
      state_d  = state_q;
      win_d    = win_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      gnt_d    = 2'b00;
      done_d   = 2'b00;
      rdata_d  = rdata_q;
      sel_d    = sel_q;
      en_d     = 1'b0;
      swe_d    = 1'b0;
      swdata_d = swdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_d   = last_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (|bus.req) begin
               win_d   = win_c;
               we_d    = bus.we[win_c];
               wdata_d = win_c ? bus.wdata[2*DATA_W-1:DATA_W] : bus.wdata[DATA_W-1:0];
               sel_d   = win_c ? bus.addr[2*AW-1:AW] : bus.addr[AW-1:0];
               gnt_d   = win_c ? 2'b10 : 2'b01;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
               last_d  = win_c;
`endif
               state_d = StSetup;
            end
         end
         StSetup: begin
            en_d     = 1'b1;
            swe_d    = we_q;
            swdata_d = wdata_q;
            state_d  = StStrobe;
         end
         StStrobe: begin
            done_d = win_q ? 2'b10 : 2'b01;
            if (!we_q) rdata_d = bus.sram_rdata;
            state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         gnt_q    <= 2'b00;
         done_q   <= 2'b00;
         rdata_q  <= '0;
         sel_q    <= '0;
         en_q     <= 1'b0;
         swe_q    <= 1'b0;
         swdata_q <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         win_q    <= win_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         gnt_q    <= gnt_d;
         done_q   <= done_d;
         rdata_q  <= rdata_d;
         sel_q    <= sel_d;
         en_q     <= en_d;
         swe_q    <= swe_d;
         swdata_q <= swdata_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
         last_q   <= last_d;
`endif
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.done       = done_q;
   assign bus.rdata      = rdata_q;
   assign bus.sram_sel   = sel_q;
   assign bus.sram_en    = en_q;
   assign bus.sram_we    = swe_q;
   assign bus.sram_wdata = swdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_sram_arbiter;
   logic clk;
   logic rst_n;
   int   nvec;
   int   nerr;
   logic [1:0] exp_g [4];

   sram_arbiter_if #(.DATA_W(8), .AW(5)) bus ();

   sram_arbiter #(.DATA_W(8), .NWORDS(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
      exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
      rst_n = 1'b0;
      bus.req = 2'b00; bus.we = 2'b00; bus.addr = '0; bus.wdata = '0; bus.sram_rdata = '0;
      cyc(2);
      chk("rst_gnt", 32'(bus.gnt), 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_rdata", 32'(bus.rdata), 0);
      chk("rst_sel", 32'(bus.sram_sel), 0);
      chk("rst_en", 32'(bus.sram_en), 0);
      chk("rst_we", 32'(bus.sram_we), 0);
      chk("rst_wdata", 32'(bus.sram_wdata), 0);

      // Write A5 to word 31 from requester 0
      rst_n = 1'b1;
      bus.req = 2'b01; bus.we = 2'b01; bus.addr = {5'd0, 5'd31}; bus.wdata = {8'h00, 8'hA5};
      cyc(1);
      chk("w_gnt", 32'(bus.gnt), 32'h1);
      chk("w_setup_en", 32'(bus.sram_en), 0);
      chk("w_setup_sel", 32'(bus.sram_sel), 31);
      bus.req = 2'b00;
      cyc(1);
      chk("w_strobe_en", 32'(bus.sram_en), 1);
      chk("w_strobe_we", 32'(bus.sram_we), 1);
      chk("w_strobe_wdata", 32'(bus.sram_wdata), 32'hA5);
      chk("w_strobe_sel", 32'(bus.sram_sel), 31);
      chk("w_strobe_gnt", 32'(bus.gnt), 0);
      cyc(1);
      chk("w_done", 32'(bus.done), 32'h1);
      chk("w_done_en", 32'(bus.sram_en), 0);
      cyc(1);
      chk("w_idle_done", 32'(bus.done), 0);
      chk("w_idle_sel", 32'(bus.sram_sel), 31);

      // Read word 31 from requester 1
      bus.req = 2'b10; bus.we = 2'b00; bus.addr = {5'd31, 5'd0}; bus.wdata = '0;
      cyc(1);
      chk("r_gnt", 32'(bus.gnt), 32'h2);
      bus.req = 2'b00; bus.sram_rdata = 8'hA5;
      cyc(1);
      chk("r_strobe_en", 32'(bus.sram_en), 1);
      chk("r_strobe_we", 32'(bus.sram_we), 0);
      cyc(1);
      chk("r_done", 32'(bus.done), 32'h2);
      chk("r_rdata", 32'(bus.rdata), 32'hA5);
      bus.sram_rdata = 8'h00;
      cyc(4);
      chk("r_rdata_hold", 32'(bus.rdata), 32'hA5);

      // Both requesting continuously
      bus.req = 2'b11; bus.we = 2'b00; bus.addr = {5'd7, 5'd3};
      for (int i = 1; i <= 16; i++) begin
         cyc(1);
         if (i % 4 == 1) begin
            chk("both_gnt", 32'(bus.gnt), 32'(exp_g[(i-1)/4]));
            chk("both_sel", 32'(bus.sram_sel), (exp_g[(i-1)/4] == 2'b10) ? 7 : 3);
         end
         if (i % 4 == 3) chk("both_done", 32'(bus.done), 32'(exp_g[(i-1)/4]));
      end
      bus.req = 2'b00;
      cyc(1);

      // Requester 0 drops req and changes inputs after grant
      bus.req = 2'b01; bus.we = 2'b01; bus.addr = {5'd9, 5'd0}; bus.wdata = {8'h00, 8'h3C};
      cyc(1);
      chk("drop_gnt", 32'(bus.gnt), 32'h1);
      chk("drop_sel", 32'(bus.sram_sel), 0);
      bus.req = 2'b00; bus.addr = {5'd9, 5'd31}; bus.wdata = {8'h00, 8'hFF};
      cyc(1);
      chk("drop_en", 32'(bus.sram_en), 1);
      chk("drop_strobe_sel", 32'(bus.sram_sel), 0);
      chk("drop_wdata", 32'(bus.sram_wdata), 32'h3C);
      chk("drop_we", 32'(bus.sram_we), 1);
      cyc(1);
      chk("drop_done", 32'(bus.done), 32'h1);
      cyc(1);

      // Reset during strobe abandons the access
      bus.req = 2'b01; bus.we = 2'b00; bus.addr = {5'd0, 5'd9};
      cyc(1);
      chk("ra_gnt", 32'(bus.gnt), 32'h1);
      bus.req = 2'b00;
      cyc(1);
      chk("ra_strobe_en", 32'(bus.sram_en), 1);
      rst_n = 1'b0;
      cyc(1);
      chk("ra_en", 32'(bus.sram_en), 0);
      chk("ra_done", 32'(bus.done), 0);
      chk("ra_rdata", 32'(bus.rdata), 0);
      chk("ra_sel", 32'(bus.sram_sel), 0);
      rst_n = 1'b1;
      cyc(1);
      chk("ra_post_done", 32'(bus.done), 0);
      chk("ra_post_en", 32'(bus.sram_en), 0);
      chk("ra_post_gnt", 32'(bus.gnt), 0);
      bus.req = 2'b01; bus.addr = {5'd0, 5'd5};
      cyc(1);
      chk("ra_new_gnt", 32'(bus.gnt), 32'h1);
      chk("ra_new_sel", 32'(bus.sram_sel), 5);
      bus.req = 2'b00;
      cyc(3);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, SRAM word width in bits.
REQ-002 Parameter: NWORDS, fixed 32, SRAM depth; word-select address is 5 bits.
REQ-003 Port: clk  in  1  single clock, all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: req  in  2  request, bit k from requester k; level, held until gnt[k].
REQ-006 Port: we  in  2  per-requester write (1) / read (0), sampled at grant.
REQ-007 Port: addr  in  10  per-requester word address, requester k on addr[5k+4:5k].
REQ-008 Port: wdata  in  2*DATA_W  per-requester write data, requester k on slice k.
REQ-009 Port: gnt  out  2  one-hot, one-cycle grant pulse.
REQ-010 Port: done  out  2  one-hot, one-cycle completion pulse.
REQ-011 Port: rdata  out  DATA_W  read data; valid while done[k] high for a read.
REQ-012 Port: sram_sel  out  5  word-line select to the 5-to-32 decoder sel input.
REQ-013 Port: sram_en  out  1  decoder enable / word-line strobe.
REQ-014 Port: sram_we  out  1  array write enable, qualified by sram_en.
REQ-015 Port: sram_wdata  out  DATA_W  array write data.
REQ-016 Port: sram_rdata  in  DATA_W  array read data, valid during strobe.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, STROBE and DONE; all outputs registered.
REQ-018 IDLE: if any req bit is high, select one winner, latch its we/addr/wdata, go to SETUP; otherwise stay in IDLE.
REQ-019 SETUP: gnt[winner]=1; sram_sel=latched addr; sram_en=0 (decoder settle cycle); next state STROBE.
REQ-020 STROBE: sram_en=1; sram_we=latched we; sram_wdata=latched wdata; sram_sel held; next state DONE.
REQ-021 On the STROBE->DONE edge, rdata SHALL load sram_rdata for reads; it SHALL remain unchanged for writes.
REQ-022 DONE: sram_en=0, sram_we=0, done[winner]=1; next state IDLE.
REQ-023 Timing: req seen in IDLE cycle T gives gnt at T+1, strobe at T+2, done at T+3, and IDLE at T+4; peak throughput is one access per 4 cycles.
REQ-024 req changes after grant SHALL neither abort nor alter the access in flight.
REQ-025 A requester's own req SHALL be ignored while its access is in flight and re-arbitrated in the next IDLE.
REQ-026 rdata SHALL hold its last value until the next read capture.
REQ-027 sram_sel SHALL hold the last accessed address in IDLE; sram_en SHALL never be high outside STROBE.
REQ-028 Addresses 0 and 31 SHALL be handled identically to all other addresses; there is no address wrap or range error.

Reset
REQ-029 While rst_n=0 at a clock edge: state=IDLE; gnt=0, done=0, rdata=0, sram_sel=0, sram_en=0, sram_we=0, sram_wdata=0; last-grant pointer=1.
REQ-030 Reset asserted mid-access SHALL abandon the access: sram_en=0 after that edge, no done pulse, and no latched request retained.

Configuration
REQ-031 Macro SRAM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not granted last wins; the pointer updates on each grant.
REQ-032 Macro SRAM_ARB_ROUND_ROBIN_EN undefined: fixed priority, requester 0 always wins; the pointer logic is absent.

Verification
REQ-033 Reset, then req=01, we=01, addr0=31, wdata0=8'hA5 -> gnt=01 at T+1; sram_sel=31, sram_en=1, sram_we=1, sram_wdata=A5 at T+2; done=01 at T+3.
REQ-034 Then req=10, we=00, addr1=31 with sram_rdata=A5 during strobe -> gnt=10, then done=10 with rdata=A5; rdata still A5 four cycles later.
REQ-035 req=11 held constantly, round-robin build -> grants alternate 01,10,01,10 at 4-cycle spacing; fixed-priority build -> grants are always 01.
REQ-036 Requester 0 drops req the cycle after gnt with addr0=0 -> access completes at address 0 and done=01 still pulses.
REQ-037 rst_n=0 during STROBE -> next cycle sram_en=0, state IDLE, no done pulse; a new req=01 after reset is granted at T+1.
